// File: rtl/io_responder.sv
// ============================================================================
// Module   : io_responder
// Brief    : CPU I/O instruction responder: debounced switch input, display
//            latch and sticky halt, with pipeline stall control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_responder #(
    parameter int DATA_WIDTH      = 32,
    parameter int SW_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  input_flag,
    input  logic                  output_flag,
    input  logic                  halt,
    input  logic [SW_WIDTH-1:0]   switches,
    input  logic                  enter_btn,
    input  logic [DATA_WIDTH-1:0] out_data,
    output logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_valid,
    output logic                  io_stall,
    output logic [DATA_WIDTH-1:0] display_value,
    output logic                  display_update,
    output logic                  waiting,
    output logic                  halted
);

    localparam logic [2:0] c_IDLE         = 3'd0;
    localparam logic [2:0] c_WAIT_PRESS   = 3'd1;
    localparam logic [2:0] c_WAIT_RELEASE = 3'd2;
    localparam logic [2:0] c_DONE         = 3'd3;
    localparam logic [2:0] c_HALTED       = 3'd4;

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic                  w_capture;
    logic                  w_display_load;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_btn_db;
    logic [c_CNT_W-1:0]    r_db_cnt;
    logic [DATA_WIDTH-1:0] r_in_data;
    logic                  r_in_valid;
    logic [DATA_WIDTH-1:0] r_display_value;
    logic                  r_display_update;
    logic                  r_halted;

    // Button path: two-flop synchronizer, then a stability counter that only
    // lets btn_db follow the synchronized level after it has held steadily.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_btn_db <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= enter_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_btn_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_CNT_LAST) begin
                r_btn_db <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (halt)
                    w_next = c_HALTED;
                else if (input_flag)
                    w_next = c_WAIT_PRESS;
            end
            c_WAIT_PRESS: begin
                if (r_btn_db) begin
                    w_next    = c_WAIT_RELEASE;
                    w_capture = 1'b1;
                end else if (!input_flag) begin
                    w_next = c_IDLE;
                end
            end
            c_WAIT_RELEASE: begin
                if (!r_btn_db)
                    w_next = c_DONE;
                else if (!input_flag)
                    w_next = c_IDLE;
            end
            c_DONE:   w_next = c_IDLE;
            c_HALTED: w_next = c_HALTED;
            default:  w_next = c_IDLE;
        endcase
    end

    assign w_display_load = (r_state == c_IDLE) && output_flag && !halt && !input_flag;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= c_IDLE;
            r_in_data        <= '0;
            r_in_valid       <= 1'b0;
            r_display_value  <= '0;
            r_display_update <= 1'b0;
            r_halted         <= 1'b0;
        end else begin
            r_state          <= w_next;
            r_in_valid       <= (w_next == c_DONE);
            r_halted         <= (w_next == c_HALTED);
            r_display_update <= w_display_load;
            if (w_capture)
                r_in_data <= DATA_WIDTH'(switches);
            if (w_display_load)
                r_display_value <= out_data;
        end
    end

    // Stall in the very first IDLE cycle of an input instruction so the PC
    // cannot advance before the FSM has taken ownership of the pipeline.
    assign io_stall = ((r_state == c_IDLE) && input_flag && !halt) ||
                      (r_state == c_WAIT_PRESS) ||
                      (r_state == c_WAIT_RELEASE) ||
                      (r_state == c_HALTED);

    assign waiting        = (r_state == c_WAIT_PRESS) || (r_state == c_WAIT_RELEASE);
    assign in_data        = r_in_data;
    assign in_valid       = r_in_valid;
    assign display_value  = r_display_value;
    assign display_update = r_display_update;
    assign halted         = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_io_responder.sv
// ============================================================================
// Module   : tb_io_responder
// Brief    : Directed, table-driven self-checking bench for io_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_responder;

    logic        clock;
    logic        reset;
    logic        input_flag;
    logic        output_flag;
    logic        halt;
    logic [15:0] switches;
    logic        enter_btn;
    logic [31:0] out_data;
    logic [31:0] in_data;
    logic        in_valid;
    logic        io_stall;
    logic [31:0] display_value;
    logic        display_update;
    logic        waiting;
    logic        halted;

    int n_total;
    int n_pass;

    io_responder #(
        .DATA_WIDTH      (32),
        .SW_WIDTH        (16),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .input_flag     (input_flag),
        .output_flag    (output_flag),
        .halt           (halt),
        .switches       (switches),
        .enter_btn      (enter_btn),
        .out_data       (out_data),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .io_stall       (io_stall),
        .display_value  (display_value),
        .display_update (display_update),
        .waiting        (waiting),
        .halted         (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        oflag;
        logic [31:0] data;
        logic [31:0] exp_disp;
        logic        exp_upd;
    } vec_t;

    vec_t vecs [6];

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_total     = 0;
        n_pass      = 0;
        reset       = 1'b1;
        input_flag  = 1'b0;
        output_flag = 1'b0;
        halt        = 1'b0;
        switches    = '0;
        enter_btn   = 1'b0;
        out_data    = '0;

        vecs[0] = '{1'b1, 32'h0000_00A5, 32'h0000_00A5, 1'b1};
        vecs[1] = '{1'b0, 32'h0000_FFFF, 32'h0000_00A5, 1'b0};
        vecs[2] = '{1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[4] = '{1'b1, 32'h8000_0001, 32'h8000_0001, 1'b1};
        vecs[5] = '{1'b0, 32'h1234_5678, 32'h8000_0001, 1'b0};

        // Reset state
        tick();
        do_reset();
        chk("rst_in_data", in_data, 32'h0);
        chk("rst_in_valid", {31'h0, in_valid}, 32'h0);
        chk("rst_io_stall", {31'h0, io_stall}, 32'h0);
        chk("rst_display_value", display_value, 32'h0);
        chk("rst_display_update", {31'h0, display_update}, 32'h0);
        chk("rst_waiting", {31'h0, waiting}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);

        // Output instruction table
        for (int i = 0; i < 6; i++) begin
            output_flag = vecs[i].oflag;
            out_data    = vecs[i].data;
            #1;
            chk($sformatf("out_stall[%0d]", i), {31'h0, io_stall}, 32'h0);
            tick();
            chk($sformatf("out_disp[%0d]", i), display_value, vecs[i].exp_disp);
            chk($sformatf("out_upd[%0d]", i), {31'h0, display_update}, {31'h0, vecs[i].exp_upd});
        end
        output_flag = 1'b0;
        tick();
        chk("out_upd_drop", {31'h0, display_update}, 32'h0);

        // Input instruction: press held 10 cycles, then release
        switches   = 16'h1234;
        input_flag = 1'b1;
        #1;
        chk("in_stall_first_cycle", {31'h0, io_stall}, 32'h1);
        tick();
        chk("in_waiting", {31'h0, waiting}, 32'h1);
        enter_btn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 6) chk("in_data_before_capture", in_data, 32'h0);
            if (k == 7) chk("in_data_capture", in_data, 32'h0000_1234);
            chk($sformatf("press_no_valid[%0d]", k), {31'h0, in_valid}, 32'h0);
            chk($sformatf("press_stall[%0d]", k), {31'h0, io_stall}, 32'h1);
        end
        enter_btn = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k < 7) begin
                chk($sformatf("rel_no_valid[%0d]", k), {31'h0, in_valid}, 32'h0);
                chk($sformatf("rel_stall[%0d]", k), {31'h0, io_stall}, 32'h1);
            end
        end
        chk("done_in_valid", {31'h0, in_valid}, 32'h1);
        chk("done_io_stall", {31'h0, io_stall}, 32'h0);
        chk("done_waiting", {31'h0, waiting}, 32'h0);
        input_flag = 1'b0;
        tick();
        chk("post_done_in_valid", {31'h0, in_valid}, 32'h0);
        chk("post_done_in_data_hold", in_data, 32'h0000_1234);

        // Glitches of 1..3 cycles must not be accepted
        switches   = 16'hBEEF;
        input_flag = 1'b1;
        tick();
        for (int g = 1; g <= 3; g++) begin
            enter_btn = 1'b1;
            for (int k = 0; k < g; k++) tick();
            enter_btn = 1'b0;
            for (int k = 0; k < 8; k++) begin
                tick();
                chk($sformatf("glitch%0d_no_valid[%0d]", g, k), {31'h0, in_valid}, 32'h0);
            end
            chk($sformatf("glitch%0d_waiting", g), {31'h0, waiting}, 32'h1);
            chk($sformatf("glitch%0d_in_data", g), in_data, 32'h0000_1234);
        end
        input_flag = 1'b0;
        tick();
        chk("abort_waiting", {31'h0, waiting}, 32'h0);
        chk("abort_in_data", in_data, 32'h0000_1234);

        // Reset while waiting for release
        switches   = 16'h55AA;
        input_flag = 1'b1;
        tick();
        enter_btn = 1'b1;
        for (int k = 0; k < 9; k++) tick();
        chk("wr_in_data", in_data, 32'h0000_55AA);
        chk("wr_waiting", {31'h0, waiting}, 32'h1);
        reset      = 1'b1;
        enter_btn  = 1'b0;
        input_flag = 1'b0;
        tick();
        chk("wr_rst_in_data", in_data, 32'h0);
        chk("wr_rst_waiting", {31'h0, waiting}, 32'h0);
        chk("wr_rst_in_valid", {31'h0, in_valid}, 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("wr_no_valid[%0d]", k), {31'h0, in_valid}, 32'h0);
        end

        // Halt has priority and is sticky
        output_flag = 1'b1;
        out_data    = 32'h0000_0077;
        tick();
        chk("pre_halt_disp", display_value, 32'h0000_0077);
        halt        = 1'b1;
        input_flag  = 1'b1;
        out_data    = 32'h0000_0099;
        #1;
        chk("halt_cycle_stall", {31'h0, io_stall}, 32'h0);
        tick();
        chk("halted", {31'h0, halted}, 32'h1);
        chk("halt_stall", {31'h0, io_stall}, 32'h1);
        chk("halt_disp_kept", display_value, 32'h0000_0077);
        chk("halt_no_update", {31'h0, display_update}, 32'h0);
        halt       = 1'b0;
        input_flag = 1'b0;
        out_data   = 32'h0000_0011;
        for (int k = 0; k < 3; k++) tick();
        chk("halt_sticky", {31'h0, halted}, 32'h1);
        chk("halt_ignores_output", display_value, 32'h0000_0077);
        chk("halt_waiting_low", {31'h0, waiting}, 32'h0);
        output_flag = 1'b0;
        do_reset();
        chk("post_halt_rst_halted", {31'h0, halted}, 32'h0);
        chk("post_halt_rst_stall", {31'h0, io_stall}, 32'h0);
        chk("post_halt_rst_disp", display_value, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
